lift_car_controller: RTL and testbench



---
 rtl/lift_car_controller.sv | 190 +++++++++++++++++++
 tb/tb_lift_car_controller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_car_controller.sv
// Per-car motion and door sequencer: SCAN-ordered stop service, floor travel timer, door dwell timer.
// Optional door_hold input is compiled in when DOOR_HOLD_EN is defined.
module lift_car_controller #(
    parameter int NUM_FLOORS  = 11,
    parameter int FLOOR_W     = 4,
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
`ifdef DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic                  req_err,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [1:0]            dir,
    output logic                  moving,
    output logic                  door_open,
    output logic                  served,
    output logic [FLOOR_W-1:0]    served_floor,
    output logic [FLOOR_W:0]      liftstate
);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b11;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int TMAX    = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W = $clog2(TMAX);
    localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

    state_t                  state, state_nx;
    logic [TIMER_W-1:0]      timer, timer_nx;
    logic [NUM_FLOORS-1:0]   pending_nx;
    logic [FLOOR_W-1:0]      floor_nx, served_floor_nx;
    logic [1:0]              dir_nx;
    logic                    moving_nx, door_nx, served_nx, err_nx;

    logic                    req_in_range, req_ok, req_here, hold;
    logic [NUM_FLOORS-1:0]   req_bit, cur_bit, arrive_bit, pending_req;
    logic [FLOOR_W-1:0]      step_floor;
    logic                    above_cur, below_cur, ahead_step, here_pending;

`ifdef DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    assign liftstate = {moving | door_open | (pending != '0), cur_floor};

    // Request decode and SCAN look-ahead relative to the current and next floor
    always_comb begin
        req_in_range = ({1'b0, req_floor} < FLOOR_LIMIT);
        req_ok       = req_valid && req_in_range;
        req_here     = req_ok && (req_floor == cur_floor);
        step_floor   = (dir == DIR_DOWN) ? cur_floor - 1'b1 : cur_floor + 1'b1;
        req_bit      = '0;
        cur_bit      = '0;
        arrive_bit   = '0;
        above_cur    = 1'b0;
        below_cur    = 1'b0;
        ahead_step   = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            req_bit[i]    = req_ok && (req_floor == FLOOR_W'(i));
            cur_bit[i]    = (cur_floor == FLOOR_W'(i));
            arrive_bit[i] = (step_floor == FLOOR_W'(i));
            if (pending[i] && (FLOOR_W'(i) > cur_floor)) above_cur = 1'b1;
            if (pending[i] && (FLOOR_W'(i) < cur_floor)) below_cur = 1'b1;
            if (pending[i] || req_bit[i]) begin
                if (dir == DIR_DOWN) begin
                    if (FLOOR_W'(i) < step_floor) ahead_step = 1'b1;
                end else if (FLOOR_W'(i) > step_floor) begin
                    ahead_step = 1'b1;
                end
            end
        end
        pending_req  = pending | req_bit;
        here_pending = |(pending & cur_bit);
    end

    always_comb begin
        state_nx        = state;
        timer_nx        = timer;
        pending_nx      = pending_req;
        floor_nx        = cur_floor;
        dir_nx          = dir;
        moving_nx       = moving;
        door_nx         = door_open;
        served_nx       = 1'b0;
        served_floor_nx = served_floor;
        err_nx          = req_valid && !req_in_range;
        case (state)
            IDLE: begin
                if (req_here || here_pending) begin
                    pending_nx      = pending_req & ~cur_bit;
                    served_nx       = 1'b1;
                    served_floor_nx = cur_floor;
                    door_nx         = 1'b1;
                    timer_nx        = DOOR_LOAD;
                    state_nx        = DOOR;
                end else if (pending == '0) begin
                    dir_nx = DIR_IDLE;
                end else begin
                    // Keep sweeping the same way while stops remain on that side
                    if (dir == DIR_UP && above_cur)        dir_nx = DIR_UP;
                    else if (dir == DIR_DOWN && below_cur) dir_nx = DIR_DOWN;
                    else if (above_cur)                    dir_nx = DIR_UP;
                    else                                   dir_nx = DIR_DOWN;
                    timer_nx  = MOVE_LOAD;
                    moving_nx = 1'b1;
                    state_nx  = MOVE;
                end
            end
            MOVE: begin
                if (timer != '0) begin
                    timer_nx = timer - 1'b1;
                end else begin
                    floor_nx = step_floor;
                    if ((pending_req & arrive_bit) != '0) begin
                        pending_nx      = pending_req & ~arrive_bit;
                        served_nx       = 1'b1;
                        served_floor_nx = step_floor;
                        timer_nx        = DOOR_LOAD;
                        moving_nx       = 1'b0;
                        door_nx         = 1'b1;
                        state_nx        = DOOR;
                    end else if (ahead_step) begin
                        timer_nx = MOVE_LOAD;
                    end else begin
                        moving_nx = 1'b0;
                        state_nx  = IDLE;
                    end
                end
            end
            DOOR: begin
                if (req_here) begin
                    pending_nx      = pending_req & ~cur_bit;
                    served_nx       = 1'b1;
                    served_floor_nx = cur_floor;
                    timer_nx        = DOOR_LOAD;
                end else if (hold) begin
                    timer_nx = DOOR_LOAD;
                end else if (timer != '0) begin
                    timer_nx = timer - 1'b1;
                end else begin
                    door_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            timer        <= '0;
            pending      <= '0;
            cur_floor    <= '0;
            dir          <= DIR_IDLE;
            moving       <= 1'b0;
            door_open    <= 1'b0;
            served       <= 1'b0;
            served_floor <= '0;
            req_err      <= 1'b0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            pending      <= pending_nx;
            cur_floor    <= floor_nx;
            dir          <= dir_nx;
            moving       <= moving_nx;
            door_open    <= door_nx;
            served       <= served_nx;
            served_floor <= served_floor_nx;
            req_err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_lift_car_controller.sv
// Scenario bench for lift_car_controller; expected service order is queued at stimulus time.
`timescale 1ns/1ps
module tb_lift_car_controller;

    localparam int NUM_FLOORS  = 11;
    localparam int FLOOR_W     = 4;
    localparam int MOVE_CYCLES = 8;
    localparam int DOOR_CYCLES = 16;

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
`ifdef DOOR_HOLD_EN
    logic                  door_hold;
`endif
    logic                  req_err;
    logic [NUM_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0]    cur_floor;
    logic [1:0]            dir;
    logic                  moving;
    logic                  door_open;
    logic                  served;
    logic [FLOOR_W-1:0]    served_floor;
    logic [FLOOR_W:0]      liftstate;

    int tests;
    int fails;
    int exp_q[$];

    lift_car_controller #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W),
        .MOVE_CYCLES(MOVE_CYCLES),
        .DOOR_CYCLES(DOOR_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
`ifdef DOOR_HOLD_EN
        .door_hold   (door_hold),
`endif
        .req_err     (req_err),
        .pending     (pending),
        .cur_floor   (cur_floor),
        .dir         (dir),
        .moving      (moving),
        .door_open   (door_open),
        .served      (served),
        .served_floor(served_floor),
        .liftstate   (liftstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the capturing rising edge.
    task automatic drive_req(input int f);
        req_valid = 1'b1;
        req_floor = FLOOR_W'(f);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_serve(input int budget, output logic got, output int n);
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (served === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_door_closed();
        int n;
        n = 0;
        while (door_open && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        tests++;
        if (pending !== '0) begin fails++; $display("FAIL reset_pending got %h want 0", pending); end
        tests++;
        if (cur_floor !== '0) begin fails++; $display("FAIL reset_cur_floor got %0d want 0", cur_floor); end
        tests++;
        if (dir !== 2'b00) begin fails++; $display("FAIL reset_dir got %b want 00", dir); end
        tests++;
        if ({moving, door_open, served, req_err} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {moving, door_open, served, req_err});
        end
        tests++;
        if (served_floor !== '0) begin fails++; $display("FAIL reset_served_floor got %0d want 0", served_floor); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (liftstate !== 5'b00000) begin fails++; $display("FAIL reset_liftstate got %b want 00000", liftstate); end
    endtask

    task automatic test_single_up();
        logic got;
        int   n;
        int   e;
        int   open_cnt;
        exp_q.push_back(3);
        drive_req(3);
        tests++;
        if (pending !== 11'h008) begin fails++; $display("FAIL up_pending got %h want 008", pending); end
        @(negedge clk);
        tests++;
        if ({dir, moving} !== 3'b111) begin fails++; $display("FAIL up_start got dir=%b moving=%b want 11/1", dir, moving); end
        wait_serve(300, got, n);
        tests++;
        if (!got) begin
            fails++; $display("FAIL up_serve_timeout got none want floor 3");
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e) || cur_floor !== 4'd3 || door_open !== 1'b1) begin
                fails++; $display("FAIL up_serve got sf=%0d cf=%0d door=%b want %0d/3/1", served_floor, cur_floor, door_open, e);
            end
        end
        // Decision cycle already elapsed, so three floors take exactly 3*MOVE_CYCLES more edges.
        tests++;
        if (n !== 3 * MOVE_CYCLES) begin fails++; $display("FAIL up_travel_time got %0d want %0d", n, 3 * MOVE_CYCLES); end
        @(negedge clk);
        tests++;
        if (served !== 1'b0) begin fails++; $display("FAIL up_served_pulse got %b want 0", served); end
        open_cnt = 1;
        while (door_open && open_cnt < 200) begin
            open_cnt++;
            @(negedge clk);
        end
        tests++;
        if (open_cnt !== DOOR_CYCLES) begin fails++; $display("FAIL up_dwell got %0d want %0d", open_cnt, DOOR_CYCLES); end
        repeat (2) @(negedge clk);
        tests++;
        if (dir !== 2'b00 || liftstate !== 5'b00011) begin
            fails++; $display("FAIL up_final got dir=%b ls=%b want 00/00011", dir, liftstate);
        end
    endtask

    task automatic test_two_stops();
        logic got;
        int   n;
        int   e;
        apply_reset();
        exp_q.push_back(2);
        exp_q.push_back(7);
        req_valid = 1'b1;
        req_floor = 4'd7;
        @(negedge clk);
        req_floor = 4'd2;
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (pending !== 11'h084) begin fails++; $display("FAIL two_pending got %h want 084", pending); end
        for (int k = 0; k < 2; k++) begin
            wait_serve(400, got, n);
            tests++;
            if (!got) begin
                fails++; $display("FAIL two_serve_timeout stop %0d got none", k);
            end else begin
                e = exp_q.pop_front();
                if (served_floor !== FLOOR_W'(e)) begin
                    fails++; $display("FAIL two_order got %0d want %0d", served_floor, e);
                end
            end
            tests++;
            if (pending !== ((k == 0) ? 11'h080 : 11'h000)) begin
                fails++; $display("FAIL two_pending_after stop %0d got %h", k, pending);
            end
        end
    endtask

    task automatic test_reversal();
        logic got;
        int   n;
        int   e;
        apply_reset();
        exp_q.push_back(8);
        drive_req(8);
        n = 0;
        while (!(cur_floor == 4'd4 && moving) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cur_floor !== 4'd4 || moving !== 1'b1) begin
            fails++; $display("FAIL rev_reach4 got cf=%0d moving=%b want 4/1", cur_floor, moving);
        end
        exp_q.push_back(1);
        drive_req(1);
        tests++;
        if (pending !== 11'h102) begin fails++; $display("FAIL rev_pending got %h want 102", pending); end
        wait_serve(400, got, n);
        tests++;
        if (!got) begin
            fails++; $display("FAIL rev_first_timeout got none want 8");
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e)) begin fails++; $display("FAIL rev_first got %0d want %0d", served_floor, e); end
        end
        tests++;
        if (pending !== 11'h002) begin fails++; $display("FAIL rev_behind_kept got %h want 002", pending); end
        wait_serve(400, got, n);
        tests++;
        if (!got) begin
            fails++; $display("FAIL rev_second_timeout got none want 1");
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e) || dir !== 2'b10) begin
                fails++; $display("FAIL rev_second got sf=%0d dir=%b want %0d/10", served_floor, dir, e);
            end
        end
        wait_door_closed();
    endtask

    task automatic test_same_floor();
        logic got;
        int   n;
        int   e;
        int   open_cnt;
        apply_reset();
        exp_q.push_back(5);
        drive_req(5);
        wait_serve(400, got, n);
        tests++;
        if (!got) begin
            fails++; $display("FAIL same_reach_timeout got none want 5");
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e)) begin fails++; $display("FAIL same_reach got %0d want %0d", served_floor, e); end
        end
        wait_door_closed();
        exp_q.push_back(5);
        drive_req(5);
        tests++;
        if (served !== 1'b1) begin
            fails++; $display("FAIL same_served got %b want 1", served);
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e)) begin fails++; $display("FAIL same_served_floor got %0d want %0d", served_floor, e); end
        end
        tests++;
        if ({moving, door_open, cur_floor, pending} !== {1'b0, 1'b1, 4'd5, 11'h000}) begin
            fails++; $display("FAIL same_state got mv=%b door=%b cf=%0d pend=%h want 0/1/5/000", moving, door_open, cur_floor, pending);
        end
        repeat (5) @(negedge clk);
        exp_q.push_back(5);
        drive_req(5);
        tests++;
        if (served !== 1'b1) begin
            fails++; $display("FAIL same_extend_served got %b want 1", served);
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e)) begin fails++; $display("FAIL same_extend_floor got %0d want %0d", served_floor, e); end
        end
        open_cnt = 0;
        while (door_open && open_cnt < 200) begin
            open_cnt++;
            @(negedge clk);
        end
        tests++;
        if (open_cnt !== DOOR_CYCLES) begin fails++; $display("FAIL same_extend_dwell got %0d want %0d", open_cnt, DOOR_CYCLES); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_req_err();
        drive_req(12);
        tests++;
        if (req_err !== 1'b1 || pending !== 11'h000) begin
            fails++; $display("FAIL err_pulse got err=%b pend=%h want 1/000", req_err, pending);
        end
        @(negedge clk);
        tests++;
        if (req_err !== 1'b0) begin fails++; $display("FAIL err_width got %b want 0", req_err); end
        tests++;
        if ({cur_floor, moving, door_open, dir} !== {4'd5, 1'b0, 1'b0, 2'b00}) begin
            fails++; $display("FAIL err_state got cf=%0d mv=%b door=%b dir=%b want 5/0/0/00", cur_floor, moving, door_open, dir);
        end
        drive_req(15);
        tests++;
        if (req_err !== 1'b1) begin fails++; $display("FAIL err_top got %b want 1", req_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_move();
        logic got;
        int   n;
        int   e;
        exp_q.push_back(9);
        drive_req(9);
        n = 0;
        while (!(cur_floor == 4'd6 && moving) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (moving !== 1'b1) begin fails++; $display("FAIL mid_moving got %b want 1", moving); end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({pending, cur_floor, dir, moving, door_open, served, req_err, served_floor, liftstate} !== '0) begin
            fails++; $display("FAIL mid_reset got pend=%h cf=%0d dir=%b mv=%b door=%b ls=%b want all 0", pending, cur_floor, dir, moving, door_open, liftstate);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(1);
        drive_req(1);
        wait_serve(200, got, n);
        tests++;
        if (!got) begin
            fails++; $display("FAIL mid_after_timeout got none want 1");
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e)) begin fails++; $display("FAIL mid_after got %0d want %0d", served_floor, e); end
        end
        wait_door_closed();
    endtask

`ifdef DOOR_HOLD_EN
    task automatic test_door_hold();
        int open_cnt;
        int e;
        exp_q.push_back(1);
        drive_req(1);
        tests++;
        if (served !== 1'b1) begin
            fails++; $display("FAIL hold_served got %b want 1", served);
        end else begin
            e = exp_q.pop_front();
            if (served_floor !== FLOOR_W'(e)) begin fails++; $display("FAIL hold_floor got %0d want %0d", served_floor, e); end
        end
        open_cnt = 1;
        door_hold = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (door_open) open_cnt++;
        end
        door_hold = 1'b0;
        while (door_open && open_cnt < 300) begin
            @(negedge clk);
            if (door_open) open_cnt++;
        end
        tests++;
        if (open_cnt !== 40 + DOOR_CYCLES) begin
            fails++; $display("FAIL hold_dwell got %0d want %0d", open_cnt, 40 + DOOR_CYCLES);
        end
    endtask
`endif

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_floor = '0;
`ifdef DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        test_reset();
        test_single_up();
        test_two_stops();
        test_reversal();
        test_same_floor();
        test_req_err();
        test_reset_mid_move();
`ifdef DOOR_HOLD_EN
        test_door_hold();
`endif
        tests++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
